reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised integer register file for the pipelined CPU generation. It has two combinational read ports and one sequential writeback port, with optional write-to-read bypass and a per-register scoreboard (busy bits) for hazard detection. Issue marks a destination busy; writeback clears it. The decode stage uses the rsN_busy outputs to stall.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2)
AW, 5, address width, must equal log2(NREGS)
SP_IDX, 2, index of the stack-pointer register
SP_RESET, 32'h0101_1111, reset value loaded into register SP_IDX (truncated/zero-extended to XLEN)
BYPASS, 1, 1 = writeback data forwarded to same-cycle reads; 0 = no forwarding

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
rs1_busy  output  1  read port 1 source has an outstanding writer
rs2_busy  output  1  read port 2 source has an outstanding writer
issue_valid  input  1  an instruction writing issue_rd is issued this cycle
issue_rd  input  AW  destination of the issued instruction
wb_valid  input  1  writeback this cycle
wb_rd  input  AW  writeback destination
wb_data  input  XLEN  writeback data
flush  input  1  clear all busy bits (pipeline flush); register contents are unaffected
busy_vec  output  NREGS  registered scoreboard, bit i = register i busy

Behaviour:
- Reset (rst_n=0 at posedge): all registers 0 except reg[SP_IDX]=SP_RESET; busy_vec=0. Register-1 reset is sampled only on the clock edge. Reset overrides issue, writeback and flush in the same cycle.
- Register 0 is hardwired:
  - Reads return 0.
  - Writes to it are ignored.
  - It is never marked busy; issue_rd=0 is a no-op.
- Reads are combinational, with zero latency:
  - rsN_data = reg[rsN_addr].
  - If BYPASS=1, wb_valid=1, wb_rd==rsN_addr and rsN_addr!=0, then rsN_data=wb_data.
- Busy outputs:
  - rsN_busy = busy_vec[rsN_addr].
  - If BYPASS=1 and the bypass condition above holds, rsN_busy=0 (the value is resolved this cycle).
  - If BYPASS=0, rsN_busy follows busy_vec with no override.
- Writeback (posedge, wb_valid=1, wb_rd!=0): reg[wb_rd] <= wb_data; busy_vec[wb_rd] <= 0. The new value is visible on reads one cycle later when BYPASS=0.
- Issue (posedge, issue_valid=1, issue_rd!=0): busy_vec[issue_rd] <= 1.
- Issue and writeback to the same rd in the same cycle: the register is written AND busy stays 1, because the new writer supersedes.
- Issue and writeback to different rd: both take effect independently.
- Flush (posedge, flush=1): busy_vec <= 0. If issue_valid is also 1, the issue bit still sets (issue wins over flush for that index). A writeback in the same cycle still writes data.
- Issue to an already-busy register: the bit stays 1. There is single-bit tracking only; in-order writeback is required by the pipeline.
- Writeback to a non-busy register is legal: data is written and the bit stays 0.
- Read addresses equal to each other: both ports return identical data and busy values.

Test Plan:
- Reset: rst_n=0 for 1 cycle, then read rs1=2, rs2=5 -> rs1_data=32'h0101_1111, rs2_data=0, busy_vec=0.
- Write/read with BYPASS=1: wb_valid=1, wb_rd=7, wb_data=32'hDEAD_BEEF, rs1_addr=7 in the same cycle -> rs1_data=DEAD_BEEF, rs1_busy=0 that cycle. Next cycle, with wb_valid=0 -> rs1_data=DEAD_BEEF.
- Register 0: wb_valid=1, wb_rd=0, wb_data=32'hFFFF_FFFF; issue_valid=1, issue_rd=0 -> reading reg 0 gives 0 and busy_vec[0]=0 at all times.
- Scoreboard: issue rd=9 -> next cycle busy_vec[9]=1 and rs2_busy=1 for rs2_addr=9. Then wb rd=9 data=5 -> rs2_busy=0 in that cycle (bypass), busy_vec[9]=0 and reg[9]=5 the cycle after.
- Same-cycle issue+wb on rd=12 (wb_data=32'h1234) -> reg[12]=32'h1234, busy_vec[12]=1. Flush with issue rd=3 -> busy_vec = only bit 3 set.
- BYPASS=0 build: wb rd=4 data=32'hA5A5 with rs1_addr=4 -> old value returned that cycle and rs1_busy equals the prior busy_vec[4]; new value appears next cycle. Reset asserted while busy_vec!=0 -> busy_vec=0 and registers at reset values.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Register file / scoreboard port bundle.
// Read, issue, writeback and flush signals shared with decode and writeback stages.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    rs1_addr;
  logic [AW-1:0]    rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             flush;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output rs1_addr,
    output rs2_addr,
    input  rs1_data,
    input  rs2_data,
    input  rs1_busy,
    input  rs2_busy,
    output issue_valid,
    output issue_rd,
    output wb_valid,
    output wb_rd,
    output wb_data,
    output flush,
    input  busy_vec
  );

  modport slave (
    input  rs1_addr,
    input  rs2_addr,
    output rs1_data,
    output rs2_data,
    output rs1_busy,
    output rs2_busy,
    input  issue_valid,
    input  issue_rd,
    input  wb_valid,
    input  wb_rd,
    input  wb_data,
    input  flush,
    output busy_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with two combinational read ports, one writeback
// port, optional writeback-to-read bypass and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter int          AW       = 5,
  parameter int          SP_IDX   = 2,
  parameter logic [31:0] SP_RESET = 32'h0101_1111,
  parameter int          BYPASS   = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);

  localparam logic [XLEN-1:0] SP_INIT = XLEN'(SP_RESET);
  localparam bit              BYP_EN  = (BYPASS != 0);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [NREGS-1:0] w_busy_nxt;
  logic             w_wb_en;
  logic             w_iss_en;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic [XLEN-1:0]  w_rs1_rf;
  logic [XLEN-1:0]  w_rs2_rf;

  assign w_wb_en  = bus.wb_valid && (bus.wb_rd != '0);
  assign w_iss_en = bus.issue_valid && (bus.issue_rd != '0);

  // Scoreboard next state: flush clears, writeback retires, issue sets last
  // so a new writer wins over both a flush and a same-cycle writeback.
  always_comb begin
    w_busy_nxt = bus.flush ? '0 : r_busy;
    if (w_wb_en) begin
      w_busy_nxt[bus.wb_rd] = 1'b0;
    end
    if (w_iss_en) begin
      w_busy_nxt[bus.issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy-bit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Register storage; x0 is never written so it holds its reset zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == SP_IDX && i != 0) ? SP_INIT : '0;
      end
    end else if (w_wb_en) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Read ports: x0 forced to zero, same-cycle writeback forwarded when enabled.
  always_comb begin
    w_rs1_rf  = (bus.rs1_addr == '0) ? '0 : r_regs[bus.rs1_addr];
    w_rs2_rf  = (bus.rs2_addr == '0) ? '0 : r_regs[bus.rs2_addr];
    w_rs1_hit = BYP_EN && w_wb_en && (bus.wb_rd == bus.rs1_addr);
    w_rs2_hit = BYP_EN && w_wb_en && (bus.wb_rd == bus.rs2_addr);
    bus.rs1_data = w_rs1_hit ? bus.wb_data : w_rs1_rf;
    bus.rs2_data = w_rs2_hit ? bus.wb_data : w_rs2_rf;
    bus.rs1_busy = w_rs1_hit ? 1'b0 : r_busy[bus.rs1_addr];
    bus.rs2_busy = w_rs2_hit ? 1'b0 : r_busy[bus.rs2_addr];
  end

  assign bus.busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: one bypassing and one non-bypassing
// instance driven with directed vectors, checked by a negedge monitor.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(32), .NREGS(32), .AW(5)) ia ();
  reg_file_sb_if #(.XLEN(32), .NREGS(32), .AW(5)) ib ();

  reg_file_sb #(.BYPASS(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  reg_file_sb #(.BYPASS(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  localparam int K_D1 = 0;
  localparam int K_D2 = 1;
  localparam int K_B1 = 2;
  localparam int K_B2 = 3;
  localparam int K_BV = 4;

  typedef struct {
    int          dut;
    int          kind;
    logic [63:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] SP = 32'h0101_1111;

  function automatic logic [63:0] bit_at(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  function automatic logic [63:0] sample(input int dut, input int kind);
    logic [63:0] r;
    r = '0;
    if (dut == 0) begin
      case (kind)
        K_D1: r = {32'd0, ia.rs1_data};
        K_D2: r = {32'd0, ia.rs2_data};
        K_B1: r = {63'd0, ia.rs1_busy};
        K_B2: r = {63'd0, ia.rs2_busy};
        default: r = {32'd0, ia.busy_vec};
      endcase
    end else begin
      case (kind)
        K_D1: r = {32'd0, ib.rs1_data};
        K_D2: r = {32'd0, ib.rs2_data};
        K_B1: r = {63'd0, ib.rs1_busy};
        K_B2: r = {63'd0, ib.rs2_busy};
        default: r = {32'd0, ib.busy_vec};
      endcase
    end
    return r;
  endfunction

  task automatic expect_v(input int dut, input int kind,
                          input logic [63:0] v, input string nm);
    exp_t e;
    e.dut  = dut;
    e.kind = kind;
    e.v    = v;
    e.nm   = nm;
    q.push_back(e);
  endtask

  // Monitor: outputs are stable mid-cycle; drain this cycle's expectations.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e   = q.pop_front();
      act = sample(e.dut, e.kind);
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ia.issue_valid = 1'b0;
    ia.issue_rd    = '0;
    ia.wb_valid    = 1'b0;
    ia.wb_rd       = '0;
    ia.wb_data     = '0;
    ia.flush       = 1'b0;
  endtask

  task automatic idle_b();
    ib.issue_valid = 1'b0;
    ib.issue_rd    = '0;
    ib.wb_valid    = 1'b0;
    ib.wb_rd       = '0;
    ib.wb_data     = '0;
    ib.flush       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    ia.rs1_addr = '0;
    ia.rs2_addr = '0;
    ib.rs1_addr = '0;
    ib.rs2_addr = '0;
    step();

    // reset values
    rst_n = 1'b1;
    ia.rs1_addr = 5'd2;
    ia.rs2_addr = 5'd5;
    ib.rs1_addr = 5'd2;
    ib.rs2_addr = 5'd5;
    expect_v(0, K_D1, {32'd0, SP}, "a_rst_sp");
    expect_v(0, K_D2, 64'd0, "a_rst_r5");
    expect_v(0, K_BV, 64'd0, "a_rst_bv");
    expect_v(0, K_B1, 64'd0, "a_rst_b1");
    expect_v(1, K_D1, {32'd0, SP}, "b_rst_sp");
    expect_v(1, K_BV, 64'd0, "b_rst_bv");
    step();

    // bypassed write/read of x7
    ia.wb_valid = 1'b1;
    ia.wb_rd    = 5'd7;
    ia.wb_data  = 32'hDEAD_BEEF;
    ia.rs1_addr = 5'd7;
    expect_v(0, K_D1, 64'hDEAD_BEEF, "a_byp_d");
    expect_v(0, K_B1, 64'd0, "a_byp_b");
    step();
    idle_a();
    expect_v(0, K_D1, 64'hDEAD_BEEF, "a_x7_next");
    step();

    // x0 write and issue are no-ops
    ia.wb_valid    = 1'b1;
    ia.wb_rd       = 5'd0;
    ia.wb_data     = 32'hFFFF_FFFF;
    ia.issue_valid = 1'b1;
    ia.issue_rd    = 5'd0;
    ia.rs1_addr    = 5'd0;
    ia.rs2_addr    = 5'd0;
    expect_v(0, K_D1, 64'd0, "a_x0_d1");
    expect_v(0, K_D2, 64'd0, "a_x0_d2");
    expect_v(0, K_B1, 64'd0, "a_x0_b1");
    step();
    idle_a();
    expect_v(0, K_D1, 64'd0, "a_x0_after");
    expect_v(0, K_BV, 64'd0, "a_x0_bv");
    step();

    // scoreboard set by issue, cleared by writeback
    ia.issue_valid = 1'b1;
    ia.issue_rd    = 5'd9;
    ia.rs2_addr    = 5'd9;
    expect_v(0, K_B2, 64'd0, "a_iss9_same");
    step();
    idle_a();
    expect_v(0, K_BV, bit_at(9), "a_iss9_bv");
    expect_v(0, K_B2, 64'd1, "a_iss9_b2");
    step();
    ia.wb_valid = 1'b1;
    ia.wb_rd    = 5'd9;
    ia.wb_data  = 32'd5;
    expect_v(0, K_B2, 64'd0, "a_wb9_b2");
    expect_v(0, K_D2, 64'd5, "a_wb9_d2");
    expect_v(0, K_BV, bit_at(9), "a_wb9_bv_hold");
    step();
    idle_a();
    expect_v(0, K_BV, 64'd0, "a_wb9_bv");
    expect_v(0, K_D2, 64'd5, "a_r9");
    expect_v(0, K_B2, 64'd0, "a_r9_b");
    step();

    // same-cycle issue and writeback on x12
    ia.issue_valid = 1'b1;
    ia.issue_rd    = 5'd12;
    ia.wb_valid    = 1'b1;
    ia.wb_rd       = 5'd12;
    ia.wb_data     = 32'h1234;
    ia.rs1_addr    = 5'd12;
    expect_v(0, K_D1, 64'h1234, "a_iw12_byp");
    expect_v(0, K_B1, 64'd0, "a_iw12_b_same");
    step();
    idle_a();
    ia.issue_valid = 1'b1;
    ia.issue_rd    = 5'd20;
    expect_v(0, K_D1, 64'h1234, "a_r12");
    expect_v(0, K_B1, 64'd1, "a_r12_busy");
    expect_v(0, K_BV, bit_at(12), "a_bv12");
    step();
    idle_a();
    expect_v(0, K_BV, bit_at(12) | bit_at(20), "a_bv12_20");
    step();

    // flush with issue x3 and writeback x20
    ia.flush       = 1'b1;
    ia.issue_valid = 1'b1;
    ia.issue_rd    = 5'd3;
    ia.wb_valid    = 1'b1;
    ia.wb_rd       = 5'd20;
    ia.wb_data     = 32'd77;
    step();
    idle_a();
    ia.rs1_addr = 5'd20;
    expect_v(0, K_BV, bit_at(3), "a_flush_bv");
    expect_v(0, K_D1, 64'd77, "a_flush_wb");
    step();

    // reissue busy x3; writeback to idle x15; equal read addresses
    ia.issue_valid = 1'b1;
    ia.issue_rd    = 5'd3;
    ia.wb_valid    = 1'b1;
    ia.wb_rd       = 5'd15;
    ia.wb_data     = 32'h55;
    step();
    idle_a();
    ia.rs1_addr = 5'd3;
    ia.rs2_addr = 5'd3;
    expect_v(0, K_BV, bit_at(3), "a_reiss_bv");
    expect_v(0, K_B1, 64'd1, "a_eq_b1");
    expect_v(0, K_B2, 64'd1, "a_eq_b2");
    expect_v(0, K_D1, 64'd0, "a_eq_d1");
    expect_v(0, K_D2, 64'd0, "a_eq_d2");
    step();
    ia.rs2_addr = 5'd15;
    expect_v(0, K_D2, 64'h55, "a_r15");
    expect_v(0, K_B2, 64'd0, "a_r15_b");
    step();

    // reset overrides issue while busy
    rst_n = 1'b0;
    ia.issue_valid = 1'b1;
    ia.issue_rd    = 5'd5;
    step();
    rst_n = 1'b1;
    idle_a();
    ia.rs1_addr = 5'd2;
    ia.rs2_addr = 5'd12;
    expect_v(0, K_BV, 64'd0, "a_rst2_bv");
    expect_v(0, K_D1, {32'd0, SP}, "a_rst2_sp");
    expect_v(0, K_D2, 64'd0, "a_rst2_r12");
    step();

    // non-bypassing instance
    ib.issue_valid = 1'b1;
    ib.issue_rd    = 5'd4;
    step();
    idle_b();
    ib.issue_valid = 1'b1;
    ib.issue_rd    = 5'd6;
    expect_v(1, K_BV, bit_at(4), "b_bv4");
    step();
    idle_b();
    ib.wb_valid = 1'b1;
    ib.wb_rd    = 5'd4;
    ib.wb_data  = 32'hA5A5;
    ib.rs1_addr = 5'd4;
    expect_v(1, K_D1, 64'd0, "b_old_d");
    expect_v(1, K_B1, 64'd1, "b_old_b");
    step();
    idle_b();
    expect_v(1, K_D1, 64'hA5A5, "b_new_d");
    expect_v(1, K_B1, 64'd0, "b_new_b");
    expect_v(1, K_BV, bit_at(6), "b_bv6");
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ib.rs2_addr = 5'd2;
    expect_v(1, K_BV, 64'd0, "b_rst_bv2");
    expect_v(1, K_D1, 64'd0, "b_rst_r4");
    expect_v(1, K_D2, {32'd0, SP}, "b_rst_sp2");
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
